// File: rtl/fir_cap_pkg.sv
// Shared sizing and state encoding for the FIR sample capture block.
package fir_cap_pkg;

  localparam int N     = 16;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/fir_cap_ram.sv
// Capture buffer: simple dual-port RAM with one write port and a registered read port.
module fir_cap_ram #(
  parameter int N     = 16,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Non-blocking read returns the pre-write word on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fir_sample_capture.sv
// Triggered capture of filter output samples into a readback buffer with running signed peaks.
// state   | meaning
// IDLE    | waiting for arm, valid samples ignored
// ARMED   | waiting for trigger (first valid or rising zero crossing)
// CAPTURE | storing valid samples until the buffer is full
// DONE    | buffer full, contents and peaks held
module fir_sample_capture #(
  parameter  int N     = fir_cap_pkg::N,
  parameter  int DEPTH = fir_cap_pkg::DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  data_in,
  input  logic          data_valid,
  input  logic          arm,
  input  logic          trig_mode,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   sample_count,
  output logic [N-1:0]  peak_max,
  output logic [N-1:0]  peak_min
);

  import fir_cap_pkg::*;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic          prev_sign;
  logic          trig;
  logic          we;

  assign trig = data_valid && (!trig_mode || (prev_sign && !data_in[N-1]));

  always_comb begin
    we = 1'b0;
    if (!reset && !arm) begin
      if (state == ARMED)        we = trig;
      else if (state == CAPTURE) we = data_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
      wr_ptr       <= '0;
      peak_max     <= '0;
      peak_min     <= '0;
      prev_sign    <= 1'b0;
    end else begin
      if (data_valid) prev_sign <= data_in[N-1];
      if (arm) begin
        state        <= ARMED;
        busy         <= 1'b1;
        done         <= 1'b0;
        sample_count <= '0;
        wr_ptr       <= '0;
        peak_max     <= '0;
        peak_min     <= '0;
      end else begin
        case (state)
          ARMED: begin
            if (trig) begin
              state        <= CAPTURE;
              sample_count <= (AW+1)'(1);
              wr_ptr       <= AW'(1);
              peak_max     <= data_in;
              peak_min     <= data_in;
            end
          end
          CAPTURE: begin
            if (data_valid) begin
              sample_count <= sample_count + 1'b1;
              if ($signed(data_in) > $signed(peak_max)) peak_max <= data_in;
              if ($signed(data_in) < $signed(peak_min)) peak_min <= data_in;
              // Pointer parks on the last address rather than wrapping.
              if (wr_ptr == AW'(DEPTH-1)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                wr_ptr <= wr_ptr + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  fir_cap_ram #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fir_sample_capture.sv
// Self-checking bench for fir_sample_capture against a sample-list reference model.
module tb_fir_sample_capture;

  localparam int W = 16;
  localparam int D = 32;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         arm;
  logic         trig_mode;
  logic [A-1:0] rd_addr;
  logic [W-1:0] rd_data;
  logic         busy;
  logic         done;
  logic [A:0]   sample_count;
  logic [W-1:0] peak_max;
  logic [W-1:0] peak_min;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: samples seen since the last arm, replayed against the trigger rule.
  logic [W-1:0] sent[$];
  logic [W-1:0] stored[$];
  logic [W-1:0] mem_img [D];
  logic [W-1:0] exp_max, exp_min;
  bit           last_sign = 1'b0;
  bit           sign_at_arm = 1'b0;
  bit           mode_at_arm = 1'b0;
  bit           armed = 1'b0;

  fir_sample_capture #(.N(W), .DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .arm          (arm),
    .trig_mode    (trig_mode),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .peak_max     (peak_max),
    .peak_min     (peak_min)
  );

  always #5 clk = ~clk;

  function automatic void build_expected();
    int t;
    bit p;
    t = -1;
    p = sign_at_arm;
    stored = {};
    if (armed) begin
      for (int i = 0; i < sent.size(); i++) begin
        if (t < 0 && (!mode_at_arm || (p && !sent[i][W-1]))) t = i;
        if (t >= 0 && stored.size() < D) stored.push_back(sent[i]);
        p = sent[i][W-1];
      end
    end
    exp_max = '0;
    exp_min = '0;
    for (int i = 0; i < stored.size(); i++) begin
      if (i == 0 || $signed(stored[i]) > $signed(exp_max)) exp_max = stored[i];
      if (i == 0 || $signed(stored[i]) < $signed(exp_min)) exp_min = stored[i];
    end
  endfunction

  function automatic void commit();
    for (int i = 0; i < stored.size(); i++) mem_img[i] = stored[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [W-1:0] v, input int gap);
    data_in    = v;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    last_sign  = v[W-1];
    if (armed) sent.push_back(v);
    repeat (gap) tick();
  endtask

  task automatic do_arm(input bit mode);
    build_expected();
    commit();
    trig_mode = mode;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    sent = {};
    sign_at_arm = last_sign;
    mode_at_arm = mode;
    armed = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; data_in = '0; data_valid = 1'b0; arm = 1'b0; trig_mode = 1'b0; rd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %h expected 0", done); end
    n_checks++; if (sample_count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", sample_count); end
    n_checks++; if (peak_max !== 16'h0) begin n_fail++; $display("FAIL reset_peak_max got %h expected 0", peak_max); end
    n_checks++; if (peak_min !== 16'h0) begin n_fail++; $display("FAIL reset_peak_min got %h expected 0", peak_min); end
    n_checks++; if (rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data got %h expected 0", rd_data); end
    send_sample(16'h1111, 0);
    n_checks++; if (sample_count !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore got count=%0d busy=%h expected 0/0", sample_count, busy); end
  endtask

  task automatic test_basic();
    do_arm(1'b0);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL basic_armed got busy=%h done=%h expected 1/0", busy, done); end
    for (int i = 0; i < D; i++) begin
      send_sample(16'(i), 0);
      if (i == D-2) begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done got %h expected 0", done); end
      end
    end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%h busy=%h expected 1/0", done, busy); end
    n_checks++; if (sample_count !== 6'd32) begin n_fail++; $display("FAIL basic_count got %0d expected 32", sample_count); end
    n_checks++; if (peak_max !== 16'd31) begin n_fail++; $display("FAIL basic_peak_max got %h expected 001f", peak_max); end
    n_checks++; if (peak_min !== 16'd0) begin n_fail++; $display("FAIL basic_peak_min got %h expected 0000", peak_min); end
    for (int k = 0; k < D; k++) begin
      rd_addr = A'(k);
      tick();
      n_checks++; if (rd_data !== 16'(k)) begin n_fail++; $display("FAIL basic_read[%0d] got %h expected %h", k, rd_data, 16'(k)); end
    end
    for (int i = 0; i < 3; i++) send_sample(16'(100 + i), 0);
    rd_addr = '0;
    tick();
    n_checks++; if (sample_count !== 6'd32 || done !== 1'b1) begin n_fail++; $display("FAIL basic_hold got count=%0d done=%h expected 32/1", sample_count, done); end
    n_checks++; if (rd_data !== 16'h0) begin n_fail++; $display("FAIL basic_no_wrap got %h expected 0000", rd_data); end
  endtask

  task automatic test_zero_cross();
    do_arm(1'b1);
    send_sample(16'h0020, 0);
    send_sample(16'h0008, 0);
    send_sample(16'hFFF8, 0);
    send_sample(16'hFFF0, 0);
    n_checks++; if (sample_count !== 6'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL zc_pre got count=%0d busy=%h expected 0/1", sample_count, busy); end
    send_sample(16'h0010, 0);
    n_checks++; if (sample_count !== 6'd1 || peak_max !== 16'h0010) begin n_fail++; $display("FAIL zc_trig got count=%0d max=%h expected 1/0010", sample_count, peak_max); end
    for (int i = 1; i < D; i++) send_sample(16'($urandom), 0);
    build_expected();
    n_checks++; if (done !== 1'b1 || sample_count !== 6'd32) begin n_fail++; $display("FAIL zc_done got done=%h count=%0d expected 1/32", done, sample_count); end
    n_checks++; if (peak_max !== exp_max || peak_min !== exp_min) begin n_fail++; $display("FAIL zc_peaks got %h/%h expected %h/%h", peak_max, peak_min, exp_max, exp_min); end
    rd_addr = '0;
    tick();
    n_checks++; if (rd_data !== 16'h0010) begin n_fail++; $display("FAIL zc_mem0 got %h expected 0010", rd_data); end
    for (int k = 1; k < D; k++) begin
      rd_addr = A'(k);
      tick();
      n_checks++; if (rd_data !== stored[k]) begin n_fail++; $display("FAIL zc_read[%0d] got %h expected %h", k, rd_data, stored[k]); end
    end
  endtask

  task automatic test_rearm();
    do_arm(1'b0);
    for (int i = 0; i < 10; i++) send_sample(16'($urandom), 0);
    n_checks++; if (sample_count !== 6'd10) begin n_fail++; $display("FAIL rearm_partial got %0d expected 10", sample_count); end
    do_arm(1'b0);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0 || sample_count !== 6'd0) begin n_fail++; $display("FAIL rearm_state got busy=%h done=%h count=%0d expected 1/0/0", busy, done, sample_count); end
    n_checks++; if (peak_max !== 16'h0 || peak_min !== 16'h0) begin n_fail++; $display("FAIL rearm_peaks got %h/%h expected 0/0", peak_max, peak_min); end
    for (int i = 0; i < D; i++) send_sample(16'($urandom), 0);
    build_expected();
    n_checks++; if (done !== 1'b1 || sample_count !== 6'd32) begin n_fail++; $display("FAIL rearm_done got done=%h count=%0d expected 1/32", done, sample_count); end
    for (int k = 0; k < D; k++) begin
      rd_addr = A'(k);
      tick();
      n_checks++; if (rd_data !== stored[k]) begin n_fail++; $display("FAIL rearm_read[%0d] got %h expected %h", k, rd_data, stored[k]); end
    end
  endtask

  task automatic test_reset_mid();
    do_arm(1'b0);
    for (int i = 0; i < 4; i++) send_sample(16'($urandom), 0);
    build_expected();
    commit();
    reset = 1'b1; arm = 1'b1; data_in = 16'h1234; data_valid = 1'b1;
    tick();
    reset = 1'b0; arm = 1'b0; data_valid = 1'b0;
    sent = {}; armed = 1'b0; last_sign = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 6'd0) begin n_fail++; $display("FAIL rstmid_state got busy=%h done=%h count=%0d expected 0/0/0", busy, done, sample_count); end
    n_checks++; if (peak_max !== 16'h0 || peak_min !== 16'h0 || rd_data !== 16'h0) begin n_fail++; $display("FAIL rstmid_regs got %h/%h/%h expected 0/0/0", peak_max, peak_min, rd_data); end
    for (int i = 0; i < 3; i++) send_sample(16'h8000 | 16'(i), 0);
    n_checks++; if (sample_count !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_ignore got count=%0d busy=%h expected 0/0", sample_count, busy); end
    for (int k = 0; k < 5; k++) begin
      rd_addr = A'(k);
      tick();
      n_checks++; if (rd_data !== mem_img[k]) begin n_fail++; $display("FAIL rstmid_read[%0d] got %h expected %h", k, rd_data, mem_img[k]); end
    end
  endtask

  task automatic test_signed_peaks();
    do_arm(1'b0);
    for (int i = 0; i < D; i++) begin
      if (i == 7)       send_sample(16'h8000, 0);
      else if (i == 20) send_sample(16'h7FFF, 0);
      else              send_sample(16'($urandom), 0);
      if (i == 10) begin
        build_expected();
        n_checks++; if (peak_max !== exp_max || peak_min !== exp_min) begin n_fail++; $display("FAIL peaks_partial got %h/%h expected %h/%h", peak_max, peak_min, exp_max, exp_min); end
      end
    end
    n_checks++; if (peak_min !== 16'h8000) begin n_fail++; $display("FAIL peaks_min got %h expected 8000", peak_min); end
    n_checks++; if (peak_max !== 16'h7FFF) begin n_fail++; $display("FAIL peaks_max got %h expected 7fff", peak_max); end
  endtask

  task automatic test_gaps();
    do_arm(1'b0);
    for (int i = 0; i < D-1; i++) send_sample(16'(i), 3);
    n_checks++; if (done !== 1'b0 || sample_count !== 6'd31) begin n_fail++; $display("FAIL gaps_early got done=%h count=%0d expected 0/31", done, sample_count); end
    send_sample(16'(D-1), 0);
    n_checks++; if (done !== 1'b1 || sample_count !== 6'd32) begin n_fail++; $display("FAIL gaps_done got done=%h count=%0d expected 1/32", done, sample_count); end
    for (int k = 0; k < D; k++) begin
      rd_addr = A'(k);
      tick();
      n_checks++; if (rd_data !== 16'(k)) begin n_fail++; $display("FAIL gaps_read[%0d] got %h expected %h", k, rd_data, 16'(k)); end
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 4; r++) begin
      do_arm(1'($urandom_range(0, 1)));
      len = $urandom_range(20, 60);
      for (int i = 0; i < len; i++) send_sample(16'($urandom), $urandom_range(0, 2));
      build_expected();
      n_checks++; if (sample_count !== 6'(stored.size())) begin n_fail++; $display("FAIL rand%0d_count got %0d expected %0d", r, sample_count, stored.size()); end
      n_checks++; if (done !== (stored.size() == D) || busy !== (stored.size() != D)) begin n_fail++; $display("FAIL rand%0d_flags got done=%h busy=%h expected size %0d", r, done, busy, stored.size()); end
      n_checks++; if (peak_max !== exp_max || peak_min !== exp_min) begin n_fail++; $display("FAIL rand%0d_peaks got %h/%h expected %h/%h", r, peak_max, peak_min, exp_max, exp_min); end
      for (int k = 0; k < stored.size(); k++) begin
        rd_addr = A'(k);
        tick();
        n_checks++; if (rd_data !== stored[k]) begin n_fail++; $display("FAIL rand%0d_read[%0d] got %h expected %h", r, k, rd_data, stored[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cross();
    test_rearm();
    test_reset_mid();
    test_signed_peaks();
    test_gaps();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
